// File: rtl/sd_spi_arbiter_pkg.sv
// Shared types and constants for the two-port SD SPI host arbiter.
// Holds FSM state encoding, owner encoding and default watchdog limit.
package sd_spi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P0   = 2'b01;
  localparam logic [1:0] OWNER_P1   = 2'b10;

  localparam int TIMEOUT_DEFAULT = 1000000;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: eligible requests in, one-hot winner out.
// Ports: elig_i eligible mask, last_i last-served port, pick_o one-hot.
module rr_arb2
  import sd_spi_arbiter_pkg::*;
(
  input  logic [1:0] elig_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = OWNER_NONE;
    unique case (elig_i)
      2'b01:   pick_o = OWNER_P0;
      2'b10:   pick_o = OWNER_P1;
      // on a tie the port not served last wins
      2'b11:   pick_o = last_i ? OWNER_P0 : OWNER_P1;
      default: pick_o = OWNER_NONE;
    endcase
  end

endmodule

// File: rtl/sd_spi_arbiter.sv
// Arbitrates one sdspihost between two requesters with a watchdog.
// Ports: reqN/gntN handshake, per-port command/status, spi_* to host.
module sd_spi_arbiter
  import sd_spi_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        r_block0,
  input  logic        r_multi_block0,
  input  logic        r_byte0,
  input  logic [31:0] block_addr0,
  input  logic        r_block1,
  input  logic        r_multi_block1,
  input  logic        r_byte1,
  input  logic [31:0] block_addr1,
  output logic        busy0,
  output logic        busy1,
  output logic        err0,
  output logic        err1,
  output logic        spi_r_block,
  output logic        spi_r_multi_block,
  output logic        spi_r_byte,
  output logic [31:0] spi_block_addr,
  input  logic        spi_busy,
  input  logic        spi_err,
  output logic [1:0]  owner,
  output logic        timeout
);

  localparam logic [CNT_W-1:0] TMAX =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [1:0]       lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] req;
  logic [1:0] elig;
  logic [1:0] pick;
  logic [2:0] cmd;
  logic       own_req;
  logic       idle;
  logic       tmo;

  assign req  = {req1, req0};
  assign elig = req & ~lock_q;

  rr_arb2 u_rr (
    .elig_i (elig),
    .last_i (last_q),
    .pick_o (pick)
  );

  // gnt_q is zero outside OWN, so DRAIN and reset
  // force the host side to all zeros
  always_comb begin
    cmd            = 3'b000;
    spi_block_addr = '0;
    unique case (1'b1)
      gnt_q[0]: begin
        cmd = {r_block0, r_multi_block0, r_byte0};
        spi_block_addr = block_addr0;
      end
      gnt_q[1]: begin
        cmd = {r_block1, r_multi_block1, r_byte1};
        spi_block_addr = block_addr1;
      end
      default: ;
    endcase
  end

  assign {spi_r_block, spi_r_multi_block,
          spi_r_byte} = cmd;

  assign own_req = |(gnt_q & req);
  assign idle    = ~spi_busy & ~|cmd;
  assign tmo     = (state_q == ST_OWN) & own_req
                 & idle & (cnt_q == TMAX);

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign owner   = gnt_q;
  assign timeout = tmo;
  assign busy0   = ~gnt_q[0] | spi_busy;
  assign busy1   = ~gnt_q[1] | spi_busy;
  assign err0    = gnt_q[0] & spi_err;
  assign err1    = gnt_q[1] & spi_err;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = '0;
    // a lockout clears once its req is sampled low
    lock_d  = lock_q & req;
    unique case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          gnt_d   = pick;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!own_req || tmo) begin
          gnt_d   = OWNER_NONE;
          last_d  = gnt_q[1];
          state_d = ST_DRAIN;
          if (tmo) lock_d = lock_d | gnt_q;
        end else if (idle) begin
          cnt_d = (cnt_q == CMAX) ? cnt_q
                : cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!spi_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= OWNER_NONE;
      last_q  <= 1'b1;
      lock_q  <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Self-checking bench for sd_spi_arbiter: vectors, corner sequences
// and a randomized run against a cycle-level reference model.
module tb_sd_spi_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, gnt0, gnt1;
  logic        r_block0, r_multi_block0, r_byte0;
  logic        r_block1, r_multi_block1, r_byte1;
  logic [31:0] block_addr0, block_addr1;
  logic        busy0, busy1, err0, err1;
  logic        spi_r_block, spi_r_multi_block, spi_r_byte;
  logic [31:0] spi_block_addr;
  logic        spi_busy, spi_err;
  logic [1:0]  owner;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_spi_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .r_block0(r_block0), .r_multi_block0(r_multi_block0),
    .r_byte0(r_byte0), .block_addr0(block_addr0),
    .r_block1(r_block1), .r_multi_block1(r_multi_block1),
    .r_byte1(r_byte1), .block_addr1(block_addr1),
    .busy0(busy0), .busy1(busy1), .err0(err0), .err1(err1),
    .spi_r_block(spi_r_block),
    .spi_r_multi_block(spi_r_multi_block),
    .spi_r_byte(spi_r_byte), .spi_block_addr(spi_block_addr),
    .spi_busy(spi_busy), .spi_err(spi_err),
    .owner(owner), .timeout(timeout)
  );

  typedef struct {
    string       nm;
    logic [2:0]  s0;
    logic [31:0] a0;
    logic [2:0]  s1;
    logic [31:0] a1;
    logic        bsy;
    logic        er;
    logic [2:0]  es;
    logic [31:0] ea;
    logic        eb0, eb1, ee0, ee1;
  } vec_t;

  vec_t vt[6];

  function automatic logic [63:0] pack(
    input logic g0, input logic g1, input logic [1:0] ow,
    input logic tm, input logic [2:0] st, input logic [31:0] ad,
    input logic b0, input logic b1, input logic e0, input logic e1);
    return {20'd0, g0, g1, ow, tm, st, ad, b0, b1, e0, e1};
  endfunction

  function automatic logic [63:0] dut_vec();
    return pack(gnt0, gnt1, owner, timeout,
                {spi_r_block, spi_r_multi_block, spi_r_byte},
                spi_block_addr, busy0, busy1, err0, err1);
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    {r_block0, r_multi_block0, r_byte0} = 3'b000;
    {r_block1, r_multi_block1, r_byte1} = 3'b000;
    block_addr0 = '0;
    block_addr1 = '0;
    spi_busy = 1'b0;
    spi_err  = 1'b0;
  endtask

  task automatic rnd_inputs();
    if ($urandom_range(0, 15) == 0) req0 = ~req0;
    if ($urandom_range(0, 15) == 0) req1 = ~req1;
    {r_block0, r_multi_block0, r_byte0} =
      ($urandom_range(0, 7) == 0) ?
      3'(1 << $urandom_range(0, 2)) : 3'b000;
    {r_block1, r_multi_block1, r_byte1} =
      ($urandom_range(0, 7) == 0) ?
      3'(1 << $urandom_range(0, 2)) : 3'b000;
    block_addr0 = $urandom();
    block_addr1 = $urandom();
    spi_busy = ($urandom_range(0, 3) == 0);
    spi_err  = ($urandom_range(0, 7) == 0);
  endtask

  // reference model: who owns, whether draining, idle run length
  int         m_own, m_last, m_run;
  bit         m_drain;
  bit [1:0]   m_lock;
  logic [2:0] s0, s1, est;
  logic [31:0] ea;
  logic [1:0] eown;
  bit         oreq, idl, tmo, e0, e1;
  logic [63:0] exp_v;

  task automatic model_reset();
    m_own = -1; m_last = 1; m_run = 0;
    m_drain = 0; m_lock = 2'b00;
  endtask

  task automatic model_eval();
    s0 = {r_block0, r_multi_block0, r_byte0};
    s1 = {r_block1, r_multi_block1, r_byte1};
    est  = (m_own == 0) ? s0 : (m_own == 1) ? s1 : 3'b000;
    ea   = (m_own == 0) ? block_addr0 :
           (m_own == 1) ? block_addr1 : 32'd0;
    eown = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    oreq = (m_own == 0 && req0) || (m_own == 1 && req1);
    idl  = !spi_busy && est == 3'b000;
    tmo  = oreq && idl && (m_run + 1 == TO);
    exp_v = pack(m_own == 0, m_own == 1, eown, tmo, est, ea,
                 (m_own == 0) ? spi_busy : 1'b1,
                 (m_own == 1) ? spi_busy : 1'b1,
                 m_own == 0 && spi_err, m_own == 1 && spi_err);
  endtask

  task automatic model_next();
    e0 = req0 && !m_lock[0];
    e1 = req1 && !m_lock[1];
    if (!req0) m_lock[0] = 0;
    if (!req1) m_lock[1] = 0;
    if (m_own >= 0) begin
      if (!oreq || tmo) begin
        if (tmo) begin
          if (m_own == 0) m_lock[0] = 1;
          else m_lock[1] = 1;
        end
        m_last = m_own; m_own = -1; m_drain = 1; m_run = 0;
      end else if (idl) m_run++;
      else m_run = 0;
    end else if (m_drain) begin
      if (!spi_busy) m_drain = 0;
    end else if (e0 && e1) m_own = (m_last == 1) ? 0 : 1;
    else if (e0) m_own = 0;
    else if (e1) m_own = 1;
  endtask

  int   bad, tpos, tcnt;
  logic g8, g9;

  initial begin
    vt[0] = '{"iso_blk", 3'b100, 32'h55, 3'b100, 32'h2B, 0, 0,
              3'b100, 32'h2B, 1, 0, 0, 0};
    vt[1] = '{"nonown_strobe", 3'b100, 32'h77, 3'b000, 32'h10,
              1, 0, 3'b000, 32'h10, 1, 1, 0, 0};
    vt[2] = '{"err_multi", 3'b000, 32'h0, 3'b010, 32'hDEADBEEF,
              0, 1, 3'b010, 32'hDEADBEEF, 1, 0, 0, 1};
    vt[3] = '{"err_byte", 3'b011, 32'h99, 3'b001, 32'h1234,
              1, 1, 3'b001, 32'h1234, 1, 1, 0, 1};
    vt[4] = '{"nonown_all", 3'b111, 32'hFFFFFFFF, 3'b000, 32'h0,
              1, 0, 3'b000, 32'h0, 1, 1, 0, 0};
    vt[5] = '{"own_all", 3'b000, 32'h0, 3'b111, 32'hA5A5A5A5,
              0, 0, 3'b111, 32'hA5A5A5A5, 1, 0, 0, 0};

    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b0;
    idle_in();
    step(); step();
    samp();
    check("reset_outs", dut_vec(),
          pack(0, 0, 2'b00, 0, 3'b000, 32'd0, 1, 1, 0, 0));
    req0 = 1'b0;
    step();
    rst_n = 1'b1;

    // tie after reset
    step();
    req0 = 1'b1; req1 = 1'b1;
    samp();
    check("tie_latency", {gnt1, gnt0}, 2'b00);
    step();
    samp();
    check("tie_first", {owner, gnt1, gnt0}, 4'b0101);
    step();
    req0 = 1'b0;
    samp();
    check("drop_hold", {gnt1, gnt0}, 2'b01);
    step();
    samp();
    check("drop_clr", {gnt1, gnt0}, 2'b00);
    step();
    samp();
    check("drain_gap", {gnt1, gnt0}, 2'b00);
    step();
    samp();
    check("tie_second", {owner, gnt1, gnt0}, 4'b1010);

    // command mux / isolation vectors while port 1 owns
    foreach (vt[i]) begin
      step();
      {r_block0, r_multi_block0, r_byte0} = vt[i].s0;
      block_addr0 = vt[i].a0;
      {r_block1, r_multi_block1, r_byte1} = vt[i].s1;
      block_addr1 = vt[i].a1;
      spi_busy = vt[i].bsy;
      spi_err  = vt[i].er;
      samp();
      check(vt[i].nm, dut_vec(),
            pack(0, 1, 2'b10, 0, vt[i].es, vt[i].ea,
                 vt[i].eb0, vt[i].eb1, vt[i].ee0, vt[i].ee1));
    end
    step();
    idle_in();
    spi_busy = 1'b1;
    samp();
    check("err_keep", {gnt1, gnt0}, 2'b10);

    // drain hold with host still busy
    step();
    req1 = 1'b0; req0 = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      samp();
      if ({owner, gnt1, gnt0} != 4'b0000) bad++;
      step();
    end
    check("drain_hold", 64'(bad), 64'd0);
    spi_busy = 1'b0;
    samp();
    check("drain_exit", {gnt1, gnt0}, 2'b00);
    step();
    samp();
    check("drain_idle", {gnt1, gnt0}, 2'b00);
    step();
    samp();
    check("drain_grant", {gnt1, gnt0}, 2'b01);

    // watchdog: this cycle is the first idle owned cycle
    tpos = 0; tcnt = 0; g8 = 1'b0; g9 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) begin
        step();
        samp();
      end
      if (timeout) begin
        tcnt++;
        if (tpos == 0) tpos = k;
      end
      if (k == 8) g8 = gnt0;
      if (k == 9) g9 = gnt0;
    end
    check("wd_pulse_pos", 64'(tpos), 64'd8);
    check("wd_pulse_cnt", 64'(tcnt), 64'd1);
    check("wd_gnt_held", 64'(g8), 64'd1);
    check("wd_revoke", 64'(g9), 64'd0);

    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      samp();
      if (gnt0 || gnt1 || timeout) bad++;
    end
    check("lockout", 64'(bad), 64'd0);
    step();
    req0 = 1'b0;
    step();
    req0 = 1'b1;
    samp();
    check("relock_wait", {gnt1, gnt0}, 2'b00);
    step();
    samp();
    check("regrant", {gnt1, gnt0}, 2'b01);

    // asynchronous reset during a multi-block read
    step();
    r_multi_block0 = 1'b1;
    block_addr0 = 32'h40;
    spi_busy = 1'b1;
    samp();
    check("mb_active", {spi_r_multi_block, spi_block_addr},
          {1'b1, 32'h40});
    #2;
    rst_n = 1'b0;
    req1 = 1'b1;
    #1;
    check("async_rst", dut_vec(),
          pack(0, 0, 2'b00, 0, 3'b000, 32'd0, 1, 1, 0, 0));
    #1;
    r_multi_block0 = 1'b0;
    spi_busy = 1'b0;
    rst_n = 1'b1;
    step();
    samp();
    check("rst_tie", {gnt1, gnt0}, 2'b01);

    // randomized run against the reference model
    step();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    idle_in();
    step();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rnd_inputs();
      samp();
      model_eval();
      check("rand", dut_vec(), exp_v);
      model_next();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
